// File: rtl/park_pkg.sv
// Shared definitions for the parking slot manager.
// Contents: status codes, request opcodes, FSM state encodings and the default lot size.
package park_pkg;

  localparam int parking_slots = 48;

  localparam logic OP_EXIT  = 1'b0;
  localparam logic OP_ENTRY = 1'b1;

  typedef enum logic [1:0] {
    ST_OK           = 2'd0,
    ST_ERR_OCCUPIED = 2'd1,
    ST_ERR_EMPTY    = 2'd2,
    ST_ERR_RANGE    = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/park_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the pointer.
// Outputs are a one-hot grant, the winner's index, and a flag that is set when any request is present.
module park_rr_arbiter
  import park_pkg::*;
#(
  parameter  int N_GATES = 2,
  localparam int GW      = (N_GATES > 1) ? $clog2(N_GATES) : 1
) (
  input  logic [N_GATES-1:0] req_i,
  input  logic [GW-1:0]      ptr_i,
  output logic [N_GATES-1:0] grant_o,
  output logic [GW-1:0]      idx_o,
  output logic               any_o
);

  int   cand;
  logic found;

  // Scan the gates in rotated order so the gate at the pointer has the highest priority.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < N_GATES; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= N_GATES) cand = cand - N_GATES;
      if (!found && req_i[GW'(cand)]) begin
        found                 = 1'b1;
        grant_o[GW'(cand)]    = 1'b1;
        idx_o                 = GW'(cand);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/parking_slot_manager.sv
// Serialises ENTRY/EXIT requests from several gates onto one per-flat occupancy bitmap.
// Saturating statistics counters for successful entries and exits are built only when PARK_STATS_EN is defined.
module parking_slot_manager
  import park_pkg::*;
#(
  parameter  int N_SLOTS = parking_slots,
  parameter  int N_GATES = 2,
  localparam int FW      = $clog2(N_SLOTS),
  localparam int GW      = (N_GATES > 1) ? $clog2(N_GATES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_GATES-1:0]    req_valid,
  output logic [N_GATES-1:0]    req_ready,
  input  logic [N_GATES-1:0]    req_op,
  input  logic [N_GATES*FW-1:0] req_flat,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [GW-1:0]         rsp_gate,
  output logic [FW-1:0]         rsp_flat,
  output logic [1:0]            rsp_status,
  output logic [FW:0]           occ_count,
  output logic                  lot_full,
  output logic                  lot_empty,
  output logic [15:0]           stat_entries,
  output logic [15:0]           stat_exits
);

  state_e               state_q, state_d;
  logic [GW-1:0]        rrPtr_q, rrPtr_d;
  logic [GW-1:0]        gate_q, gate_d;
  logic                 op_q, op_d;
  logic [FW-1:0]        flat_q, flat_d;
  status_e              status_q, status_d;
  logic [N_SLOTS-1:0]   bitmap_q, bitmap_d;
  logic [FW:0]          occCount_q, occCount_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;

  logic [N_GATES-1:0]   grant;
  logic [GW-1:0]        winIdx;
  logic                 anyReq;
  logic                 winOp;
  logic [FW-1:0]        winFlat;
  logic                 inRange;
  logic                 slotBusy;
  status_e              checkStatus;
  logic                 okFire;

  park_rr_arbiter #(.N_GATES(N_GATES)) uArb (
    .req_i   (req_valid),
    .ptr_i   (rrPtr_q),
    .grant_o (grant),
    .idx_o   (winIdx),
    .any_o   (anyReq)
  );

  always_comb begin
    winOp   = 1'b0;
    winFlat = '0;
    for (int g = 0; g < N_GATES; g++) begin
      if (winIdx == GW'(g)) begin
        winOp   = req_op[g];
        winFlat = req_flat[g*FW +: FW];
      end
    end
  end

  // Out-of-range flats never touch the bitmap, so the busy lookup is masked by the range test.
  always_comb begin
    inRange  = (int'(flat_q) < N_SLOTS);
    slotBusy = inRange && bitmap_q[flat_q];
    if (!inRange)                          checkStatus = ST_ERR_RANGE;
    else if (op_q == OP_ENTRY && slotBusy) checkStatus = ST_ERR_OCCUPIED;
    else if (op_q == OP_EXIT && !slotBusy) checkStatus = ST_ERR_EMPTY;
    else                                   checkStatus = ST_OK;
  end

  assign okFire = (state_q == S_CHECK) && (checkStatus == ST_OK);

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    gate_d     = gate_q;
    op_d       = op_q;
    flat_d     = flat_q;
    status_d   = status_q;
    bitmap_d   = bitmap_q;
    occCount_d = occCount_q;
    full_d     = full_q;
    empty_d    = empty_q;
    req_ready  = '0;
    case (state_q)
      S_IDLE: begin
        if (anyReq) begin
          req_ready = grant;
          gate_d    = winIdx;
          op_d      = winOp;
          flat_d    = winFlat;
          rrPtr_d   = (int'(winIdx) == N_GATES - 1) ? '0 : winIdx + GW'(1);
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        status_d = checkStatus;
        if (checkStatus == ST_OK) begin
          bitmap_d[flat_q] = (op_q == OP_ENTRY);
          occCount_d = (op_q == OP_ENTRY) ? occCount_q + (FW+1)'(1) : occCount_q - (FW+1)'(1);
          full_d     = (occCount_d == (FW+1)'(N_SLOTS));
          empty_d    = (occCount_d == '0);
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rrPtr_q    <= '0;
      gate_q     <= '0;
      op_q       <= OP_EXIT;
      flat_q     <= '0;
      status_q   <= ST_OK;
      bitmap_q   <= '0;
      occCount_q <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      gate_q     <= gate_d;
      op_q       <= op_d;
      flat_q     <= flat_d;
      status_q   <= status_d;
      bitmap_q   <= bitmap_d;
      occCount_q <= occCount_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_gate   = gate_q;
  assign rsp_flat   = flat_q;
  assign rsp_status = status_q;
  assign occ_count  = occCount_q;
  assign lot_full   = full_q;
  assign lot_empty  = empty_q;

`ifdef PARK_STATS_EN
  logic [15:0] statEntries_q, statExits_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statEntries_q <= '0;
      statExits_q   <= '0;
    end else if (okFire) begin
      if (op_q == OP_ENTRY && statEntries_q != 16'hFFFF) statEntries_q <= statEntries_q + 16'd1;
      if (op_q == OP_EXIT && statExits_q != 16'hFFFF)    statExits_q   <= statExits_q + 16'd1;
    end
  end

  assign stat_entries = statEntries_q;
  assign stat_exits   = statExits_q;
`else
  assign stat_entries = '0;
  assign stat_exits   = '0;
`endif

endmodule

// File: tb/tb_parking_slot_manager.sv
// Self-checking bench for parking_slot_manager (48 slots, 2 gates): vector table, corner sequences
// and randomized traffic against a slot-array reference model.
module tb_parking_slot_manager;

  logic        clk, rst;
  logic [1:0]  req_valid, req_ready, req_op;
  logic [11:0] req_flat;
  logic        rsp_valid, rsp_ready;
  logic [0:0]  rsp_gate;
  logic [5:0]  rsp_flat;
  logic [1:0]  rsp_status;
  logic [6:0]  occ_count;
  logic        lot_full, lot_empty;
  logic [15:0] stat_entries, stat_exits;

  parking_slot_manager #(.N_SLOTS(48), .N_GATES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_flat(req_flat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gate(rsp_gate), .rsp_flat(rsp_flat),
    .rsp_status(rsp_status), .occ_count(occ_count), .lot_full(lot_full), .lot_empty(lot_empty),
    .stat_entries(stat_entries), .stat_exits(stat_exits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit         occModel[48];
  int         rrModel, statE, statX;
  logic [1:0] pendValid;
  logic       pendOp[2];
  logic [5:0] pendFlat[2];

  typedef struct {
    int         gate;
    logic       op;
    logic [5:0] flat;
    int         hold;
    logic [1:0] expStatus;
    int         expOcc;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int modelCount();
    int n = 0;
    for (int i = 0; i < 48; i++) n += occModel[i];
    return n;
  endfunction

  // Reference rules: range first, then occupancy; only successful requests change state.
  function automatic logic [1:0] modelApply(input logic op, input int flat);
    if (flat >= 48) return 2'd3;
    if (op) begin
      if (occModel[flat]) return 2'd1;
      occModel[flat] = 1'b1;
      statE++;
      return 2'd0;
    end
    if (!occModel[flat]) return 2'd2;
    occModel[flat] = 1'b0;
    statX++;
    return 2'd0;
  endfunction

  function automatic int expStat(input int v);
`ifdef PARK_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic applyReset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    pendValid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 48; i++) occModel[i] = 1'b0;
    rrModel = 0;
    statE = 0;
    statX = 0;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle and at least one pending request; serves exactly one.
  task automatic applyStimulus(input int hold, output int gotGate, output logic [1:0] gotStatus,
                               output int gotOcc);
    int         win, budget, cnt;
    logic [1:0] expSt, expReady;
    win = -1;
    req_valid = pendValid;
    req_op    = {pendOp[1], pendOp[0]};
    req_flat  = {pendFlat[1], pendFlat[0]};
    rsp_ready = (hold == 0);
    for (int k = 0; k < 2; k++) begin
      int c = (rrModel + k) % 2;
      if (win < 0 && pendValid[c]) win = c;
    end
    #1;
    expReady = (win == 0) ? 2'b01 : 2'b10;
    checkOutput("req_ready_grant", 32'(req_ready), 32'(expReady));
    @(posedge clk);
    #1;
    pendValid[win] = 1'b0;
    req_valid = pendValid;
    rrModel = (win + 1) % 2;
    expSt = modelApply(pendOp[win], int'(pendFlat[win]));
    cnt = modelCount();
    @(negedge clk);
    budget = 0;
    while (!rsp_valid && budget < 8) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_gate", 32'(rsp_gate), 32'(win));
    checkOutput("rsp_flat", 32'(rsp_flat), 32'(pendFlat[win]));
    checkOutput("rsp_status", 32'(rsp_status), 32'(expSt));
    checkOutput("occ_count", 32'(occ_count), 32'(cnt));
    checkOutput("lot_full", 32'(lot_full), 32'(cnt == 48));
    checkOutput("lot_empty", 32'(lot_empty), 32'(cnt == 0));
    checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
    checkOutput("stat_entries", 32'(stat_entries), 32'(expStat(statE)));
    checkOutput("stat_exits", 32'(stat_exits), 32'(expStat(statX)));
    gotGate   = int'(rsp_gate);
    gotStatus = rsp_status;
    gotOcc    = int'(occ_count);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_status", 32'(rsp_status), 32'(expSt));
      checkOutput("hold_flat", 32'(rsp_flat), 32'(pendFlat[win]));
      checkOutput("hold_gate", 32'(rsp_gate), 32'(win));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         gGate, gOcc, seen;
    logic [1:0] gSt;
    rst = 1'b1; req_valid = '0; req_op = '0; req_flat = '0; rsp_ready = 1'b1;
    pendValid = '0;

    vecs[0] = '{gate:0, op:1'b1, flat:6'd5,  hold:0, expStatus:2'd0, expOcc:1};
    vecs[1] = '{gate:0, op:1'b0, flat:6'd7,  hold:0, expStatus:2'd2, expOcc:1};
    vecs[2] = '{gate:1, op:1'b1, flat:6'd50, hold:4, expStatus:2'd3, expOcc:1};
    vecs[3] = '{gate:1, op:1'b1, flat:6'd5,  hold:0, expStatus:2'd1, expOcc:1};
    vecs[4] = '{gate:0, op:1'b1, flat:6'd47, hold:1, expStatus:2'd0, expOcc:2};
    vecs[5] = '{gate:1, op:1'b0, flat:6'd5,  hold:0, expStatus:2'd0, expOcc:1};
    vecs[6] = '{gate:0, op:1'b1, flat:6'd63, hold:0, expStatus:2'd3, expOcc:1};
    vecs[7] = '{gate:1, op:1'b0, flat:6'd47, hold:0, expStatus:2'd0, expOcc:0};

    applyReset();
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_occ", 32'(occ_count), 32'd0);
    checkOutput("reset_empty", 32'(lot_empty), 32'd1);
    checkOutput("reset_full", 32'(lot_full), 32'd0);
    checkOutput("reset_rsp_fields", {26'd0, rsp_gate, rsp_status, rsp_flat[2:0]}, 32'd0);
    checkOutput("reset_rsp_flat", 32'(rsp_flat), 32'd0);
    checkOutput("reset_stats", {stat_entries, stat_exits}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      pendValid = '0;
      pendValid[vecs[v].gate] = 1'b1;
      pendOp[vecs[v].gate]    = vecs[v].op;
      pendFlat[vecs[v].gate]  = vecs[v].flat;
      applyStimulus(vecs[v].hold, gGate, gSt, gOcc);
      checkOutput("tbl_gate", 32'(gGate), 32'(vecs[v].gate));
      checkOutput("tbl_status", 32'(gSt), 32'(vecs[v].expStatus));
      checkOutput("tbl_occ", 32'(gOcc), 32'(vecs[v].expOcc));
    end

    // Both gates enter flat 9 together: gate 0 wins, gate 1 is refused.
    applyReset();
    pendValid = 2'b11;
    pendOp[0] = 1'b1; pendOp[1] = 1'b1;
    pendFlat[0] = 6'd9; pendFlat[1] = 6'd9;
    applyStimulus(0, gGate, gSt, gOcc);
    checkOutput("same_first_gate", 32'(gGate), 32'd0);
    checkOutput("same_first_status", 32'(gSt), 32'd0);
    applyStimulus(0, gGate, gSt, gOcc);
    checkOutput("same_second_gate", 32'(gGate), 32'd1);
    checkOutput("same_second_status", 32'(gSt), 32'd1);
    checkOutput("same_occ", 32'(gOcc), 32'd1);

    // Fill the whole lot, then free one slot.
    applyReset();
    for (int f = 0; f < 48; f++) begin
      pendValid = (f % 2 == 0) ? 2'b01 : 2'b10;
      pendOp[f % 2] = 1'b1;
      pendFlat[f % 2] = 6'(f);
      applyStimulus(0, gGate, gSt, gOcc);
    end
    checkOutput("fill_full", 32'(lot_full), 32'd1);
    checkOutput("fill_occ", 32'(occ_count), 32'd48);
    pendValid = 2'b01; pendOp[0] = 1'b1; pendFlat[0] = 6'd10;
    applyStimulus(0, gGate, gSt, gOcc);
    checkOutput("full_reentry", 32'(gSt), 32'd1);
    pendValid = 2'b10; pendOp[1] = 1'b0; pendFlat[1] = 6'd0;
    applyStimulus(0, gGate, gSt, gOcc);
    checkOutput("exit0_status", 32'(gSt), 32'd0);
    checkOutput("exit0_occ", 32'(gOcc), 32'd47);
    checkOutput("exit0_full", 32'(lot_full), 32'd0);

    // Reset while the request is in CHECK: no response and nothing recorded.
    req_valid = 2'b01; req_op = 2'b01; req_flat = {6'd0, 6'd3};
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 48; i++) occModel[i] = 1'b0;
    rrModel = 0; statE = 0; statX = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    checkOutput("midreset_no_rsp", 32'(seen), 32'd0);
    checkOutput("midreset_occ", 32'(occ_count), 32'd0);
    checkOutput("midreset_empty", 32'(lot_empty), 32'd1);

    for (int k = 0; k < 4; k++) begin
      pendValid = 2'b01;
      pendOp[0] = (k < 3);
      pendFlat[0] = (k < 3) ? 6'(k + 1) : 6'd2;
      applyStimulus(0, gGate, gSt, gOcc);
    end
    checkOutput("stats_entries", 32'(stat_entries), 32'(expStat(3)));
    checkOutput("stats_exits", 32'(stat_exits), 32'(expStat(1)));

    for (int r = 0; r < 150; r++) begin
      int hold;
      pendValid = 2'($urandom_range(1, 3));
      for (int g = 0; g < 2; g++) begin
        pendOp[g] = 1'($urandom_range(0, 1));
        pendFlat[g] = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(48, 63))
                                                   : 6'($urandom_range(0, 15));
      end
      hold = $urandom_range(0, 2);
      while (pendValid != 2'b00) applyStimulus(hold, gGate, gSt, gOcc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
